// File: rtl/bridge_timer.sv
// Bus-mapped programmable down-counter with one-shot and auto-reload modes, driving a CP0 interrupt line.
// Build option: define TIMER_STATUS_EN to add the sticky write-one-to-clear EXPIRED flag at CTRL[4].
module bridge_timer #(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  localparam logic [1:0]  ADDR_CTRL   = 2'd0;
  localparam logic [1:0]  ADDR_PRESET = 2'd1;
  localparam logic [1:0]  ADDR_COUNT  = 2'd2;
  localparam logic [15:0] PRESC_MAX   = 16'(PRESCALE - 1);

  state_t           state;
  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic             irq_pend;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic [15:0]      presc;
`ifdef TIMER_STATUS_EN
  logic             expired;
`endif

  logic ctrl_wr;
  logic preset_wr;
  logic tick;
  logic expire;
  logic auto_reload;
  logic status_bit;
  logic unused_wdata;

  assign ctrl_wr     = we && (addr == ADDR_CTRL);
  assign preset_wr   = we && (addr == ADDR_PRESET);
  assign tick        = (state == S_CNT) && en && (presc == PRESC_MAX);
  // Reaching the bottom of the count: COUNT of 0 or 1 both end the period.
  assign expire      = tick && (count <= CNT_W'(1));
  assign auto_reload = (mode == 2'b01);
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      en       <= 1'b0;
      mode     <= 2'b00;
      im       <= 1'b0;
      irq_pend <= 1'b0;
      preset   <= '0;
      count    <= '0;
      presc    <= '0;
`ifdef TIMER_STATUS_EN
      expired  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (en) state <= S_LOAD;
        end
        S_LOAD: begin
          count <= preset;
          presc <= '0;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (tick) begin
            presc <= '0;
            if (expire) begin
              count    <= '0;
              irq_pend <= 1'b1;
              state    <= S_INT;
            end else begin
              count <= count - CNT_W'(1);
            end
          end else begin
            presc <= presc + 16'd1;
          end
        end
        S_INT: begin
          if (auto_reload) begin
            irq_pend <= 1'b0;
            state    <= S_LOAD;
          end else begin
            en    <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Bus writes come last so they override the FSM's own EN/pend updates on the same edge.
      if (ctrl_wr) begin
        en       <= wdata[0];
        mode     <= wdata[2:1];
        im       <= wdata[3];
        irq_pend <= 1'b0;
      end
      if (preset_wr) preset <= wdata[CNT_W-1:0];

`ifdef TIMER_STATUS_EN
      if (ctrl_wr && wdata[4]) expired <= 1'b0;
      if (expire) expired <= 1'b1;
`endif
    end
  end

`ifdef TIMER_STATUS_EN
  assign status_bit = expired;
`else
  assign status_bit = 1'b0;
`endif

  always_comb begin
    rdata = 32'h0;
    case (addr)
      ADDR_CTRL:   rdata = {27'h0, status_bit, im, mode, en};
      ADDR_PRESET: rdata = 32'(preset);
      ADDR_COUNT:  rdata = 32'(count);
      default:     rdata = 32'h0;
    endcase
  end

  assign irq = irq_pend & im;

endmodule
